// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: FSM encodings, the subtract-mode
// selector value and a width helper for sizing counters.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic SUB_MODE = 1'b1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple adder; c_msb is the carry into the slice MSB,
// which the top needs on the final slice to form signed overflow.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign co    = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full-adder cell used as the building block of the ripple slices.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: processes one CHUNK-bit slice per clock from
// LSB to MSB and publishes sum and flags only when the last slice completes.
module chunked_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] add1,
   input  logic [WIDTH-1:0] add2,
   input  logic             cin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (clog2(NCHUNK) > 1) ? clog2(NCHUNK) : 1;

   state_t           state, next_state;
   logic [WIDTH-1:0] op_a, op_b, res, res_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [CHUNK-1:0] slice_a, slice_b, slice_s;
   logic             slice_co, slice_cmsb;
   logic             last, accept;
   int               slice_base;

   assign slice_base = int'(cnt) * CHUNK;
   assign slice_a    = op_a[slice_base +: CHUNK];
   assign slice_b    = op_b[slice_base +: CHUNK];
   assign last       = (cnt == CW'(NCHUNK - 1));
   assign accept     = start && ready;

   chunk_adder #(.CHUNK(CHUNK)) u_slice (
      .a     (slice_a),
      .b     (slice_b),
      .ci    (carry),
      .s     (slice_s),
      .co    (slice_co),
      .c_msb (slice_cmsb)
   );

   // Merge the freshly computed slice into the partial result.
   always_comb begin
      res_next = res;
      res_next[slice_base +: CHUNK] = slice_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ready is a pure decode of the state register, so start never reaches it.
   always_comb begin
      next_state = state;
      ready      = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) next_state = RUN;
         end
         RUN: begin
            if (last) next_state = DONE;
         end
         DONE: begin
            ready      = 1'b1;
            done       = 1'b1;
            next_state = start ? RUN : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Subtraction is add1 + ~add2 + 1, so the operand is inverted at capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a  <= '0;
         op_b  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else if (accept) begin
         op_a  <= add1;
         op_b  <= (sub == SUB_MODE) ? ~add2 : add2;
         carry <= (sub == SUB_MODE) ? 1'b1 : cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         res   <= res_next;
         carry <= slice_co;
         cnt   <= cnt + 1'b1;
         if (last) begin
            sum  <= res_next;
            cout <= slice_co;
            ovf  <= slice_co ^ slice_cmsb;
            zero <= (res_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: directed vectors and handshake/reset sequences on a
// 16/4 instance, plus random operands on 16/4, 8/8 and 8/1 against a model.
module tb_chunked_adder;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   typedef struct {
      logic        sub;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } vec_t;

   logic        clk, rst, start, sub, cin;
   logic [15:0] add1, add2;

   logic        rdy16, done16, cout16, ovf16, zero16;
   logic [15:0] sum16;
   logic        rdy8a, done8a, cout8a, ovf8a, zero8a;
   logic [7:0]  sum8a;
   logic        rdy8b, done8b, cout8b, ovf8b, zero8b;
   logic [7:0]  sum8b;

   int total = 0;
   int bad   = 0;

   chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .add1(add1), .add2(add2),
      .cin(cin), .ready(rdy16), .done(done16), .sum(sum16), .cout(cout16),
      .ovf(ovf16), .zero(zero16)
   );

   chunked_adder #(.WIDTH(8), .CHUNK(8)) u_dut8a (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .add1(add1[7:0]),
      .add2(add2[7:0]), .cin(cin), .ready(rdy8a), .done(done8a), .sum(sum8a),
      .cout(cout8a), .ovf(ovf8a), .zero(zero8a)
   );

   chunked_adder #(.WIDTH(8), .CHUNK(1)) u_dut8b (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .add1(add1[7:0]),
      .add2(add2[7:0]), .cin(cin), .ready(rdy8b), .done(done8b), .sum(sum8b),
      .cout(cout8b), .ovf(ovf8b), .zero(zero8b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Plain two's-complement arithmetic on a w-bit word.
   function automatic res_t refModel(input int w, input logic s,
                                     input logic [15:0] a, input logic [15:0] b,
                                     input logic c);
      longint unsigned mask, aa, bb, t, sv;
      res_t r;
      mask = (64'd1 << w) - 1;
      aa   = 64'(a) & mask;
      bb   = s ? (~64'(b) & mask) : (64'(b) & mask);
      t    = aa + bb + (s ? 64'd1 : 64'(c));
      sv   = t & mask;
      r.sum  = 16'(sv);
      r.cout = ((t >> w) & 64'd1) != 0;
      r.ovf  = (((aa >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) &&
               (((sv >> (w-1)) & 1) != ((aa >> (w-1)) & 1));
      r.zero = (sv == 0);
      return r;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive a request across one rising edge; returns #1 after that edge.
   task automatic applyStimulus(input logic s, input logic [15:0] a,
                                input logic [15:0] b, input logic c);
      @(negedge clk);
      sub = s; add1 = a; add2 = b; cin = c; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Edges are counted including the accepting edge.
   task automatic waitDone16(input int first, output int lat);
      lat = first;
      while (!done16 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic checkOutput(input string name, input logic [15:0] es,
                              input logic ec, input logic eo, input logic ez,
                              input int elat, input int lat);
      checkValue({name, "_lat"},  32'(lat),    32'(elat));
      checkValue({name, "_sum"},  32'(sum16),  32'(es));
      checkValue({name, "_cout"}, 32'(cout16), 32'(ec));
      checkValue({name, "_ovf"},  32'(ovf16),  32'(eo));
      checkValue({name, "_zero"}, 32'(zero16), 32'(ez));
   endtask

   task automatic waitAllReady();
      int n;
      n = 0;
      while (!(rdy16 && rdy8a && rdy8b) && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkValue("all_ready", 32'(rdy16 && rdy8a && rdy8b), 32'd1);
   endtask

   vec_t vecs[5];

   initial begin
      int   lat, ndone, l16, l8a, l8b;
      res_t m;
      logic [15:0] ra, rb;
      logic        rs, rc;

      vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};

      rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; add1 = '0; add2 = '0;
      repeat (2) @(posedge clk);
      #1;
      checkValue("rst_ready", 32'(rdy16),  32'd1);
      checkValue("rst_done",  32'(done16), 32'd0);
      checkValue("rst_sum",   32'(sum16),  32'd0);
      checkValue("rst_flags", {29'd0, cout16, ovf16, zero16}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
         waitDone16(1, lat);
         checkOutput($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout,
                     vecs[i].ovf, vecs[i].zero, 5, lat);
         @(posedge clk);
         #1;
         checkValue($sformatf("vec%0d_done_pulse", i), 32'(done16), 32'd0);
      end

      // A request raised while busy must be ignored.
      applyStimulus(1'b0, 16'h0001, 16'h0001, 1'b0);
      checkValue("hs_ready_low", 32'(rdy16), 32'd0);
      @(negedge clk);
      add1 = 16'h00FF; add2 = 16'h0001; start = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone16(3, lat);
      checkOutput("hs_ignore", 16'h0002, 1'b0, 1'b0, 1'b0, 5, lat);

      // Back-to-back request raised in the DONE cycle.
      add1 = 16'h00FF; add2 = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkValue("b2b_done_low",  32'(done16), 32'd0);
      checkValue("b2b_ready_low", 32'(rdy16),  32'd0);
      waitDone16(1, lat);
      checkOutput("b2b", 16'h0100, 1'b0, 1'b0, 1'b0, 5, lat);
      @(posedge clk);
      #1;
      checkValue("b2b_done_pulse", 32'(done16), 32'd0);

      // Reset in the second RUN cycle aborts with no done pulse.
      applyStimulus(1'b0, 16'hAAAA, 16'h5555, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkValue("abort_ready", 32'(rdy16),  32'd1);
      checkValue("abort_done",  32'(done16), 32'd0);
      checkValue("abort_sum",   32'(sum16),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done16) ndone++;
      end
      checkValue("abort_no_done", 32'(ndone), 32'd0);
      applyStimulus(1'b0, 16'h0003, 16'h0004, 1'b0);
      waitDone16(1, lat);
      checkOutput("after_abort", 16'h0007, 1'b0, 1'b0, 1'b0, 5, lat);

      // Random operands on all three parameterisations at once.
      for (int i = 0; i < 30; i++) begin
         waitAllReady();
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         applyStimulus(rs, ra, rb, rc);
         l16 = 0; l8a = 0; l8b = 0;
         for (int e = 2; e <= 40 && (l16 == 0 || l8a == 0 || l8b == 0); e++) begin
            @(posedge clk);
            #1;
            if (done16 && l16 == 0) l16 = e;
            if (done8a && l8a == 0) l8a = e;
            if (done8b && l8b == 0) l8b = e;
         end
         m = refModel(16, rs, ra, rb, rc);
         checkOutput($sformatf("rnd16_%0d", i), m.sum, m.cout, m.ovf, m.zero, 5, l16);
         m = refModel(8, rs, ra, rb, rc);
         checkValue($sformatf("rnd8a_%0d_lat", i), 32'(l8a), 32'd2);
         checkValue($sformatf("rnd8a_%0d_res", i), {21'd0, sum8a, cout8a, ovf8a, zero8a},
                    {21'd0, m.sum[7:0], m.cout, m.ovf, m.zero});
         checkValue($sformatf("rnd8b_%0d_lat", i), 32'(l8b), 32'd9);
         checkValue($sformatf("rnd8b_%0d_res", i), {21'd0, sum8b, cout8b, ovf8b, zero8b},
                    {21'd0, m.sum[7:0], m.cout, m.ovf, m.zero});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
